// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : RV32M funct3 codes, mul/div FSM state encoding and operand-sign helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } md_state_e;

   function automatic logic md_a_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic md_b_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // funct3 bit 2 separates the divide group from the multiply group
   function automatic logic md_is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_core.sv
// ============================================================================
// Module : muldiv_core
// Brief  : Unsigned shift-add multiply / restoring divide, one bit per step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   output logic            last,
   output logic [XLEN-1:0] acc_hi,
   output logic [XLEN-1:0] acc_lo
);

   localparam int CW = $clog2(XLEN) + 1;

   // Shared accumulator: product {hi,lo} for multiply, {remainder,quotient} for divide
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic              div_q, div_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic              div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_ge    = (div_shift >= {1'b0, opb_q});

      acc_d = acc_q;
      opb_d = opb_q;
      div_d = div_q;
      cnt_d = cnt_q;

      if (flush) begin
         cnt_d = '0;
      end else if (load) begin
         acc_d = {{XLEN{1'b0}}, a_mag};
         opb_d = b_mag;
         div_d = is_div;
         cnt_d = CW'(XLEN);
      end else if (step && (cnt_q != '0)) begin
         if (div_q) begin
            acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
         end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
         end
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         opb_q <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         opb_q <= opb_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign last   = (cnt_q == CW'(1));
   assign acc_hi = acc_q[2*XLEN-1:XLEN];
   assign acc_lo = acc_q[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative RV32M multiply/divide with valid/ready request and response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
   import cpu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            busy
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic            a_neg_q, a_neg_d;
   logic            b_neg_q, b_neg_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            core_load, core_step, core_last;
   logic [XLEN-1:0] core_hi, core_lo;

   logic            a_neg_in, b_neg_in;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] quot_fix, rem_fix;

   always_comb begin
      a_neg_in = md_a_signed(req_op) & req_a[XLEN-1];
      b_neg_in = md_b_signed(req_op) & req_b[XLEN-1];
      a_mag    = a_neg_in ? -req_a : req_a;
      b_mag    = b_neg_in ? -req_b : req_b;
      div_zero = md_is_div(req_op) && (req_b == '0);
      div_ovf  = ((req_op == MD_DIV) || (req_op == MD_REM)) &&
                 (req_a == INT_MIN) && (req_b == '1);

      prod_fix = (a_neg_q ^ b_neg_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
      quot_fix = (a_neg_q ^ b_neg_q) ? -core_lo : core_lo;
      rem_fix  = a_neg_q ? -core_hi : core_hi;
   end

   assign req_ready = (state_q == IDLE) && !flush;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      result_d  = result_q;
      core_load = 1'b0;
      core_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               a_neg_d = a_neg_in;
               b_neg_d = b_neg_in;
               if (div_zero) begin
                  result_d = req_op[1] ? req_a : '1;
                  state_d  = DONE;
               end else if (div_ovf) begin
                  result_d = req_op[1] ? '0 : INT_MIN;
                  state_d  = DONE;
               end else begin
                  core_load = 1'b1;
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            core_step = 1'b1;
            if (core_last) state_d = FIX;
         end
         FIX: begin
            if (md_is_div(op_q)) begin
               result_d = op_q[1] ? rem_fix : quot_fix;
            end else begin
               result_d = (op_q == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            end
            state_d = DONE;
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a same-cycle response handshake
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= MD_MUL;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         result_q <= result_d;
      end
   end

   muldiv_core #(
      .XLEN (XLEN)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .load   (core_load),
      .step   (core_step),
      .is_div (md_is_div(req_op)),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .last   (core_last),
      .acc_hi (core_hi),
      .acc_lo (core_lo)
   );

   assign resp_valid  = (state_q == DONE);
   assign resp_result = result_q;
   assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Scoreboard bench for muldiv_unit with directed RV32M vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'b000;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_result;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: latency on first sight, stability while held, value on handshake
   bit          seen = 1'b0;
   logic [31:0] held = '0;
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (sb.size() == 0) begin
            if (!seen) chk("unexpected_resp_valid", 32'(resp_valid), 32'd0);
            seen = 1'b1;
         end else begin
            if (!seen) begin
               seen = 1'b1;
               held = resp_result;
               chk({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
            end else begin
               chk({sb[0].name, "_stable"}, resp_result, held);
            end
            if (resp_ready) begin
               chk(sb[0].name, resp_result, sb[0].res);
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name, input bit push);
      int n = 0;
      @(negedge clk);
      req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (push) sb.push_back('{exp, cyc, lat, name});
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_low;
      int n;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul", 1'b1);
      busy_low = 0;
      repeat (33) begin
         @(negedge clk);
         if (!busy) busy_low++;
      end
      chk("mul_busy_low_cycles", 32'(busy_low), 32'd0);
      drain();

      issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh",   1'b1);
      issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu",  1'b1);
      issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu", 1'b1);
      issue(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, "div",    1'b1);
      issue(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, "rem",    1'b1);
      issue(OP_DIVU,   32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34, "divu",   1'b1);
      issue(OP_REMU,   32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 34, "remu",   1'b1);
      issue(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  "div_by0",  1'b1);
      issue(OP_REMU,   32'd5,         32'd0,         32'h0000_0005, 1,  "remu_by0", 1'b1);
      issue(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf",  1'b1);
      issue(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf",  1'b1);
      drain();

      resp_ready = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "bp_divu", 1'b1);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_a     = ~req_a;
         req_valid = ~req_valid;
         #1;
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_resp_valid_drop", 32'(resp_valid), 32'd0);
      chk("bp_req_ready_after", 32'(req_ready), 32'd1);
      issue(OP_REMU, 32'd100, 32'd7, 32'd2, 34, "bp_remu", 1'b1);
      drain();

      issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 34, "flushed", 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_resp_valid", 32'(resp_valid), 32'd0);
      repeat (40) @(negedge clk);
      issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 34, "post_flush_div", 1'b1);
      drain();

      issue(OP_MUL, 32'd3, 32'd5, 32'd0, 34, "reset_victim", 1'b0);
      repeat (5) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_resp_valid", 32'(resp_valid), 32'd0);
      chk("arst_resp_result", resp_result, 32'd0);
      #1;
      rst = 1'b0;
      issue(OP_MUL, 32'd3, 32'd5, 32'd15, 34, "post_reset_mul", 1'b1);
      drain();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide responder for the EX stage. The pipeline issues one request over a valid/ready handshake and stalls until the result returns over a second valid/ready handshake. It covers all eight M-extension ops with full RISC-V edge-case semantics, replacing single-cycle combinational MUL/DIV/REM paths in the timing-critical datapath.

Parameters:
XLEN, 32, operand/result width; counter width is clog2(XLEN)+1.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort (branch/trap); discards in-flight op
req_valid  in  1  request present
req_ready  out  1  unit can accept; = (state==IDLE) && !flush
req_op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_a  in  XLEN  rs1 operand
req_b  in  XLEN  rs2 operand
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_result  out  XLEN  result
busy  out  1  state != IDLE (hazard-unit stall source)

Behaviour:
- Reset (async, active-high): state=IDLE, resp_valid=0, resp_result=0, busy=0, counter=0. req_ready=1 once rst deasserts.
- Accept: req_valid && req_ready at edge T latches op and operand magnitudes, plus sign flags: a signed for MULH/MULHSU/DIV/REM; b signed for MULH/DIV/REM.
- States: IDLE -> CALC (normal accept) or DONE (special case); CALC -> FIX after XLEN iterations; FIX -> DONE; DONE -> IDLE on resp_ready.
- Multiply: unsigned shift-add over XLEN CALC cycles on magnitudes into a 2*XLEN product. FIX negates the 2*XLEN product if the sign flags differ. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per CALC cycle on magnitudes. FIX negates the quotient if the operand signs differ and the remainder if the dividend is negative. The remainder takes the dividend's sign.
- Latency: for a normal op accepted at edge T, resp_valid is high after edge T+XLEN+2, i.e. 34 cycles for XLEN=32.
- Special cases, resolved at accept with no iteration; resp_valid is high after edge T+1:
  - div-by-zero: DIV/DIVU return all-ones; REM/REMU return req_a.
  - signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- DONE: resp_valid=1; resp_result stays stable until resp_valid && resp_ready; resp_valid drops at that edge; req_ready=1 the next cycle. No back-to-back accept in DONE.
- Operand inputs are ignored while not IDLE; changes have no effect.
- flush: any state -> IDLE at the next edge; resp_valid=0 after that edge; the result is discarded. flush overrides a concurrent resp handshake (treated as not consumed). flush forces req_ready low, so no accept occurs that cycle.
- rst mid-operation: all outputs return to reset values immediately, without waiting for clk.
- All internal arithmetic is unsigned on magnitudes; the magnitude of 0x80000000 is 2^31 and fits XLEN bits unsigned.

Decomposition:
- Shared package (cpu_pkg): MD_MUL..MD_REMU funct3 localparams and the state encoding IDLE/CALC/FIX/DONE.
- The decoder maps its MUL/DIV/REM ALU codes onto funct3 through the package.
- Sub-module: muldiv_core (shift-add / restoring-subtract iteration datapath with counter). The sign handling, special-case detection and handshake FSM stay in muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; resp_valid exactly 34 cycles after the accept edge; busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC; REMU -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, both with resp_valid after 1 cycle. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE and toggle req_a/req_valid -> resp_result stable, req_ready=0. Raise resp_ready -> resp_valid drops, req_ready=1 next cycle, next request accepted.
- Flush: flush 10 cycles into CALC -> no resp_valid ever, IDLE next cycle, a new request returns the correct result. Async rst pulse mid-CALC between edges -> busy=0 and resp_valid=0 immediately.
